// File: rtl/router_pkg.sv
// router_pkg: header field layout, port limit and input FSM encoding shared by the router front-end.
package router_pkg;
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_W = 2;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_LEN_W = 6;
  localparam int MAX_PORTS = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PARITY,
    S_DROP
  } state_t;
endpackage

// File: rtl/router_input_ctrl_if.sv
// router_input_ctrl_if: upstream byte handshake, per-port FIFO write side and packet status pulses.
interface router_input_ctrl_if #(parameter int NUM_PORTS = 3);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic [NUM_PORTS-1:0] wfull;
  logic [NUM_PORTS-1:0] winc;
  logic [7:0] wdata;
  logic pkt_done;
  logic parity_err;
  logic drop;
  logic busy;
  modport master (
    output in_valid, in_data, wfull,
    input in_ready, winc, wdata, pkt_done, parity_err, drop, busy
  );
  modport slave (
    input in_valid, in_data, wfull,
    output in_ready, winc, wdata, pkt_done, parity_err, drop, busy
  );
endinterface

// File: rtl/router_input_ctrl.sv
// router_input_ctrl: decodes packet headers and steers bytes into one of NUM_PORTS FIFOs, checking XOR parity.
module router_input_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input logic clk,
  input logic rst,
  router_input_ctrl_if.slave bus
);
  localparam logic [2:0] NP = 3'(NUM_PORTS);
  state_t state;
  logic [7:0] hdr_reg;
  logic [7:0] par;
  logic [5:0] cnt;
  logic [HDR_DEST_W-1:0] dest;
  logic [HDR_DEST_W-1:0] in_dest;
  logic [HDR_LEN_W-1:0] in_len;
  logic [MAX_PORTS-1:0] full_v;
  logic full;
  logic fwd;
  logic acc;
  logic wr;
  // Zero-extended full vector lets an out-of-range dest index safely while in DROP.
  always_comb begin
    dest = hdr_reg[HDR_DEST_LSB +: HDR_DEST_W];
    in_dest = bus.in_data[HDR_DEST_LSB +: HDR_DEST_W];
    in_len = bus.in_data[HDR_LEN_LSB +: HDR_LEN_W];
    full_v = MAX_PORTS'(bus.wfull);
    full = full_v[dest];
    fwd = state == S_PAYLOAD || state == S_PARITY;
    bus.in_ready = !rst && (state == S_IDLE || state == S_DROP || (fwd && !full));
    acc = bus.in_valid && bus.in_ready;
    wr = !rst && (state == S_HDR ? !full : fwd && acc);
    bus.wdata = !wr ? 8'h00 : state == S_HDR ? hdr_reg : bus.in_data;
    bus.busy = state != S_IDLE;
  end
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_winc
    assign bus.winc[i] = wr && dest == HDR_DEST_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hdr_reg <= '0;
      cnt <= '0;
      par <= '0;
      bus.pkt_done <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.drop <= 1'b0;
    end else begin
      bus.pkt_done <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.drop <= 1'b0;
      case (state)
        S_IDLE: if (acc) begin
          hdr_reg <= bus.in_data;
          cnt <= in_len;
          par <= bus.in_data;
          state <= ({1'b0, in_dest} < NP) ? S_HDR : S_DROP;
        end
        S_HDR: if (!full) state <= cnt != 6'd0 ? S_PAYLOAD : S_PARITY;
        S_PAYLOAD: if (acc) begin
          par <= par ^ bus.in_data;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= S_PARITY;
        end
        S_PARITY: if (acc) begin
          bus.pkt_done <= 1'b1;
          bus.parity_err <= bus.in_data != par;
          state <= S_IDLE;
        end
        S_DROP: if (acc) begin
          if (cnt == 6'd0) begin
            bus.pkt_done <= 1'b1;
            bus.parity_err <= bus.in_data != par;
            bus.drop <= 1'b1;
            state <= S_IDLE;
          end else begin
            par <= par ^ bus.in_data;
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/router_input_ctrl.md
# router_input_ctrl

Upstream packet front-end of the router: accepts a byte stream of packets, decodes the destination from the header, and drives the write side (`winc`, `wdata`) of one of NUM_PORTS per-port asynchronous FIFOs. Writes are throttled by each FIFO's `wfull`. Packets addressed to a non-existent port are consumed and discarded. The block sits directly upstream of the per-port FIFO write logic. It also checks an XOR parity trailer and flags errors per packet.

## Interface
- NUM_PORTS, 3, number of output FIFOs; header dest values >= NUM_PORTS are invalid (max 4, 2-bit dest field)
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  `in_data` holds a byte
- in_data  in  8  packet byte
- in_ready  out  1  byte is taken on the edge where `in_valid & in_ready`
- wfull  in  NUM_PORTS  full flag from each port's FIFO write logic
- winc  out  NUM_PORTS  one-hot write request to the selected FIFO
- wdata  out  8  byte written with `winc`
- pkt_done  out  1  one-cycle pulse: packet completed (forwarded or dropped)
- parity_err  out  1  one-cycle pulse alongside `pkt_done` when parity mismatched
- drop  out  1  one-cycle pulse alongside `pkt_done` for an invalid-dest packet
- busy  out  1  high in any state other than IDLE

## Operation
- Packet format:
  - header byte: [1:0] = dest, [7:2] = payload length L (0..63)
  - then L payload bytes
  - then one parity byte = XOR of the header and all payload bytes
- FSM states: IDLE, HDR, PAYLOAD, PARITY, DROP.
- IDLE:
  - `in_ready`=1.
  - On accept: latch the header into hdr_reg, load cnt=L, set par=header.
  - Go to HDR if dest < NUM_PORTS, else DROP.
- HDR:
  - `in_ready`=0.
  - `winc[dest]` = !`wfull[dest]`; `wdata` = hdr_reg.
  - When written: go to PAYLOAD if L>0, else PARITY.
  - While `wfull[dest]`=1: stay in HDR.
- PAYLOAD:
  - `in_ready` = !`wfull[dest]`.
  - `winc[dest]` = `in_valid & in_ready`; `wdata` = `in_data`.
  - Each accept: par ^= byte, cnt--.
  - At cnt==1 accept: go to PARITY.
- PARITY:
  - Same handshake as PAYLOAD. The parity byte is forwarded to the FIFO.
  - On accept: compare with par, return to IDLE.
- DROP:
  - `in_ready`=1 and `winc` stays 0.
  - Consumes L payload bytes plus the parity byte, then returns to IDLE.
  - The parity check still runs.
- Outputs:
  - `winc` is combinational and never asserted while `wfull[dest]`=1.
  - At most one `winc` bit is high at a time.
  - `wdata` is 0 whenever `winc`=0.
  - Status pulses (`pkt_done`, `parity_err`, `drop`) are registered.
- Arithmetic: cnt is 6 bits; par is 8 bits.
- Boundaries:
  - `wfull` rising mid-payload: stall with no loss; resume on the cycle `wfull` falls.
  - `in_valid`=0 mid-packet: hold state, cnt and par.
  - L=0: the packet is header + parity only.
  - NUM_PORTS=4: DROP is unreachable.
- Reset:
  - Effective on the clocked edge; returns the FSM to IDLE and clears hdr_reg, cnt and par.
  - While `rst`=1: `in_ready`=0 and `winc`=0.
  - A partial packet in flight is abandoned. The FIFO keeps any bytes already written.
- Reset values: `in_ready`=0 during reset, then 1 in IDLE; `winc`=0, `wdata`=0, `pkt_done`=0, `parity_err`=0, `drop`=0, `busy`=0.

## Timing
- Header accepted at cycle t; header written at t+1 if not full.
- Payload byte k is accepted and written in the same cycle (zero latency to `winc`).
- Without stalls, a packet takes L+3 cycles from header accept to parity accept.
- `pkt_done`/`parity_err`/`drop` are high in the cycle after the parity accept. That cycle is IDLE, so the next header can be accepted in it. Back-to-back packets therefore cost L+3 cycles each.
- Dropped packet: L+2 cycles (no HDR write cycle… DROP entered at t+1 consuming immediately).

## Structure
- Shared package `router_pkg`:
  - header field positions HDR_DEST_LSB=0, HDR_DEST_W=2, HDR_LEN_LSB=2, HDR_LEN_W=6
  - FSM state encoding
  - MAX_PORTS=4
- Single module, no sub-module.
- Parity accumulator and counter are inline registers.
- `winc` is built by one-hot decode of hdr_reg dest, gated by the handshake.

## Test plan
- Reset, then header 0x0D (dest 1, L=3), payload 0xA1 0xB2 0xC3, parity 0x0D^0xA1^0xB2^0xC3=0xDD, no stalls:
  - `winc`=3'b010 for 5 consecutive cycles starting t+1
  - `wdata` sequence 0x0D,0xA1,0xB2,0xC3,0xDD
  - `pkt_done`=1 and `parity_err`=0 one cycle after the parity accept.
- Same packet with `wfull[1]`=1 for 3 cycles after the second payload byte:
  - `in_ready`=0 and `winc`=0 during the stall
  - no byte lost or duplicated; same 5-byte `wdata` sequence.
- Header 0x07 (dest 3, L=1), payload 0x55, parity 0x52 (NUM_PORTS=3):
  - `winc` never asserted
  - `drop`=1 and `pkt_done`=1; state returns to IDLE.
- Header 0x00 (dest 0, L=0), parity 0xFF:
  - `winc[0]` writes 0x00 then 0xFF
  - `parity_err`=1 with `pkt_done`.
- `rst` asserted after the first payload byte of a L=5 packet:
  - the next cycle shows `busy`=0, `winc`=0
  - a fresh header 0x08 (dest 0, L=2) is then processed correctly.
- Two back-to-back L=1 packets with `in_valid` held high:
  - second header accepted in the `pkt_done` cycle
  - total 8 cycles from first header to second `pkt_done`.
